frame_readout_uart: RTL and testbench
=====================================

# frame_readout_uart

Reads a captured frame back out of the frame buffer filled by the camera capture path and transmits it byte by byte to the host over an 8N1 asynchronous serial line. It is the read/transmit counterpart of the OV7670 capture interface. It walks the same line/column address space that the capture data path writes, and it serializes each stored byte LSB-first. It sits between the frame-buffer memory read port and the board TX pin.

## Interface
Parameters:
- LINES, 176, number of stored lines
- COLUMNS, 288, bytes stored per line
- S_DATA, 8, byte width (fixed at 8 for UART framing)
- S_LINE, 8, line address width
- S_COLUMN, 9, column address width
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200)

Ports:
- clock  in  1  system clock, all logic on its rising edge
- reset  in  1  asynchronous, active-low reset
- iniciar  in  1  start request (level); an internal edge detector turns its rising edge into a one-cycle pulse
- frame_pronto  in  1  high while a complete frame is held in the buffer
- mem_data  in  S_DATA  frame-buffer read data, valid one cycle after mem_re
- mem_re  out  1  frame-buffer read enable, one-cycle pulse
- mem_linha  out  S_LINE  read line address
- mem_coluna  out  S_COLUMN  read column address
- TX  out  1  serial output, idle high
- ocupado  out  1  high from the accepted start until the last stop bit ends
- fim  out  1  one-cycle pulse after the last byte's stop bit
- db_estado  out  4  current state encoding

## Operation
States and codes:
- INICIAL 0: waits for a start pulse.
- LE_MEM 1: asserts mem_re.
- ESPERA_DADO 2: latches mem_data into the shift register.
- START 3: drives TX low.
- DADOS 4: sends 8 bits, LSB first.
- STOP 5: drives TX high.
- PROXIMO 6: advances the address.
- FIM 7: pulses fim and returns to INICIAL.

Transitions:
- INICIAL→LE_MEM only on a start pulse with frame_pronto=1. A start pulse while frame_pronto=0 is ignored.
- LE_MEM→ESPERA_DADO→START unconditionally.
- START→DADOS→STOP are timed by the bit counter.
- STOP→PROXIMO.
- PROXIMO→LE_MEM, or →FIM when the address was (LINES-1, COLUMNS-1).

Addressing and ordering:
- Row-major: the column advances fastest.
- At column = COLUMNS-1 the column wraps to 0 and the line increments.
- The counters clear on the accepted start pulse.

Busy and reset behaviour:
- Start pulses during ocupado=1 are ignored. A frame is never restarted mid-transfer.
- frame_pronto falling mid-transfer is ignored; the transfer completes.
- Reset asserted at any point: the state returns to INICIAL and TX returns high asynchronously. A partial byte is abandoned, not completed.

## Timing
Reset values:
- TX=1; ocupado, fim and mem_re = 0.
- Addresses = 0; db_estado = 0.

Start and memory read:
- ocupado rises the cycle after the start pulse. That is 2 cycles after the iniciar rising edge, because the edge detector takes one cycle.
- mem_re is high for exactly the LE_MEM cycle.
- mem_data is sampled in ESPERA_DADO, one cycle later.
- The address is stable from LE_MEM through the end of STOP.

Bit timing:
- Each serial bit (start, 8 data, stop) lasts exactly CLKS_PER_BIT cycles.
- The bit-cycle counter is ceil(log2(CLKS_PER_BIT)) bits wide.
- The bit index counter is 3 bits and saturates at 7.

Byte and frame durations:
- Per byte: 10·CLKS_PER_BIT + 3 cycles (LE_MEM, ESPERA_DADO, PROXIMO).
- Whole frame: LINES·COLUMNS·(10·CLKS_PER_BIT+3) cycles, plus the FIM cycle.

End of frame:
- fim is high for the single FIM cycle.
- ocupado falls in the same cycle that fim rises.
- A new start is accepted from the next cycle.

## Structure
- Shared package: state codes (INICIAL…FIM), the UART frame constant of 10 bits, and a clog2 helper for the counter widths.
- Sub-module serial_tx_byte: accepts a byte with a one-cycle load pulse, drives TX, and returns a done pulse at the end of the stop bit.
  - It owns START/DADOS/STOP timing.
  - The top FSM then sees a single "transmitting" wait state that is still reported on db_estado via the sub-module phase.
- Reuse the existing edge_detector for iniciar.

## Test plan
Use LINES=2, COLUMNS=3, CLKS_PER_BIT=4 unless stated.
- Reset: hold reset=0 for 3 cycles → TX=1, ocupado=0, db_estado=0, mem_re=0; release → no activity without iniciar.
- Full frame: memory preloaded with 0x00..0x05, frame_pronto=1, iniciar rises.
  - Addresses (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) are read in that order.
  - TX carries those bytes LSB-first with 4-cycle bits.
  - fim pulses once, 6·43+1 cycles after ocupado rises.
- Bit pattern: byte 0xA5 → TX sequence 0,1,0,1,0,0,1,0,1,1, each bit held exactly 4 cycles.
- Ignored start: iniciar with frame_pronto=0 → stays in INICIAL. A second iniciar edge mid-transfer → address sequence unchanged, exactly one fim.
- Reset mid-byte: assert reset during data bit 3 of byte (0,1) → TX=1 immediately. After release and a new iniciar, the transfer restarts at (0,0).
- Wrap at default size: LINES=176, COLUMNS=288, CLKS_PER_BIT=1 → the column wraps 287→0 with the line incrementing, and the final read is (175,287) before fim.

Source files
------------

// File: rtl/frame_readout_uart_pkg.sv
// Shared definitions for the frame-buffer readout UART: FSM state codes,
// UART framing constant and counter-width helpers.
package frame_readout_uart_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    LE_MEM      = 4'd1,
    ESPERA_DADO = 4'd2,
    START       = 4'd3,
    DADOS       = 4'd4,
    STOP        = 4'd5,
    PROXIMO     = 4'd6,
    FIM         = 4'd7
  } estado_t;

  localparam int unsigned UART_FRAME_BITS = 10;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(value)) w = w + 1;
    return w;
  endfunction

  // A one-cycle bit period still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: registered one-cycle pulse on each 0->1 of sinal.
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic pulso
);

  logic anterior;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      anterior <= 1'b0;
      pulso    <= 1'b0;
    end else begin
      anterior <= sinal;
      pulso    <= sinal & ~anterior;
    end
  end

endmodule

// File: rtl/frame_readout_uart_serial_tx_byte.sv
// 8N1 byte serializer: load latches a byte, TX carries start, 8 data bits
// LSB-first and stop; done is high in the last cycle of the stop bit.
module serial_tx_byte
  import frame_readout_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic [3:0] fase
);

  localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  estado_t          phase;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             bit_end;

  assign bit_end = (cnt == LAST);
  assign done    = (phase == STOP) && bit_end;
  assign fase    = phase;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase <= INICIAL;
      tx    <= 1'b1;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (phase)
        INICIAL: begin
          if (load) begin
            shreg <= data;
            tx    <= 1'b0;
            cnt   <= '0;
            idx   <= '0;
            phase <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt   <= '0;
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
            phase <= DADOS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DADOS: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == 3'd7) begin
              tx    <= 1'b1;
              phase <= STOP;
            end else begin
              idx   <= idx + 1'b1;
              tx    <= shreg[0];
              shreg <= {1'b0, shreg[7:1]};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            phase <= INICIAL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          phase <= INICIAL;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/frame_readout_uart.sv
// Reads the captured frame row-major from the frame buffer and sends each
// byte to the host over an 8N1 serial line.
module frame_readout_uart
  import frame_readout_uart_pkg::*;
#(
  parameter int unsigned LINES        = 176,
  parameter int unsigned COLUMNS      = 288,
  parameter int unsigned S_DATA       = 8,
  parameter int unsigned S_LINE       = 8,
  parameter int unsigned S_COLUMN     = 9,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                frame_pronto,
  input  logic [S_DATA-1:0]   mem_data,
  output logic                mem_re,
  output logic [S_LINE-1:0]   mem_linha,
  output logic [S_COLUMN-1:0] mem_coluna,
  output logic                TX,
  output logic                ocupado,
  output logic                fim,
  output logic [3:0]          db_estado
);

  localparam logic [S_LINE-1:0]   LAST_LINE = S_LINE'(LINES - 1);
  localparam logic [S_COLUMN-1:0] LAST_COL  = S_COLUMN'(COLUMNS - 1);

  estado_t    estado;
  logic       partida;
  logic       carrega;
  logic       enviado;
  logic [3:0] fase_tx;

  edge_detector u_edge (
    .clock (clock),
    .reset (reset),
    .sinal (iniciar),
    .pulso (partida)
  );

  serial_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clock (clock),
    .reset (reset),
    .load  (carrega),
    .data  (mem_data[7:0]),
    .tx    (TX),
    .done  (enviado),
    .fase  (fase_tx)
  );

  // START stands for the whole serializer wait; its phase fills in 3/4/5.
  assign carrega   = (estado == ESPERA_DADO);
  assign db_estado = (estado == START) ? fase_tx : estado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= INICIAL;
      mem_re     <= 1'b0;
      mem_linha  <= '0;
      mem_coluna <= '0;
      ocupado    <= 1'b0;
      fim        <= 1'b0;
    end else begin
      case (estado)
        INICIAL: begin
          if (partida && frame_pronto) begin
            mem_linha  <= '0;
            mem_coluna <= '0;
            mem_re     <= 1'b1;
            ocupado    <= 1'b1;
            estado     <= LE_MEM;
          end
        end
        LE_MEM: begin
          mem_re <= 1'b0;
          estado <= ESPERA_DADO;
        end
        ESPERA_DADO: estado <= START;
        START: begin
          if (enviado) estado <= PROXIMO;
        end
        PROXIMO: begin
          if ((mem_linha == LAST_LINE) && (mem_coluna == LAST_COL)) begin
            fim     <= 1'b1;
            ocupado <= 1'b0;
            estado  <= FIM;
          end else begin
            if (mem_coluna == LAST_COL) begin
              mem_coluna <= '0;
              mem_linha  <= mem_linha + 1'b1;
            end else begin
              mem_coluna <= mem_coluna + 1'b1;
            end
            mem_re <= 1'b1;
            estado <= LE_MEM;
          end
        end
        FIM: begin
          fim    <= 1'b0;
          estado <= INICIAL;
        end
        default: begin
          mem_re  <= 1'b0;
          ocupado <= 1'b0;
          fim     <= 1'b0;
          estado  <= INICIAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_readout_uart.sv
// Self-checking bench for frame_readout_uart: table of frame transfers with
// address/byte scoreboards, plus bit-timing, reset and wrap sequences.
module tb_frame_readout_uart;

  localparam int L     = 2;
  localparam int C     = 3;
  localparam int CPB   = 4;
  localparam int BYTE  = 10 * CPB + 3;
  localparam int FRAME = L * C * BYTE;
  localparam int WL    = 6;
  localparam int WC    = 288;

  logic       clock, reset, iniciar, frame_pronto;
  logic [7:0] mem_data;
  logic       mem_re, TX, ocupado, fim;
  logic [7:0] mem_linha;
  logic [8:0] mem_coluna;
  logic [3:0] db_estado;

  logic       w_iniciar, w_pronto, w_mem_re, w_tx, w_ocupado, w_fim;
  logic [7:0] w_mem_data, w_linha;
  logic [8:0] w_coluna;
  logic [3:0] w_estado;

  frame_readout_uart #(.LINES(L), .COLUMNS(C), .CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .frame_pronto(frame_pronto),
    .mem_data(mem_data), .mem_re(mem_re), .mem_linha(mem_linha),
    .mem_coluna(mem_coluna), .TX(TX), .ocupado(ocupado), .fim(fim),
    .db_estado(db_estado)
  );

  // Wide-column instance; a full 176x288 frame would exceed the cycle budget.
  frame_readout_uart #(.LINES(WL), .COLUMNS(WC), .CLKS_PER_BIT(1)) u_wrap (
    .clock(clock), .reset(reset), .iniciar(w_iniciar), .frame_pronto(w_pronto),
    .mem_data(w_mem_data), .mem_re(w_mem_re), .mem_linha(w_linha),
    .mem_coluna(w_coluna), .TX(w_tx), .ocupado(w_ocupado), .fim(w_fim),
    .db_estado(w_estado)
  );

  assign w_mem_data = 8'h3C;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] mem [L*C];
  always @(posedge clock) begin
    if (mem_re && (int'(mem_linha) * C + int'(mem_coluna) < L * C))
      mem_data <= mem[int'(mem_linha) * C + int'(mem_coluna)];
  end

  int checks = 0;
  int errors = 0;
  int fim_cnt = 0;
  bit mon_en = 1'b0;
  int exp_addr_q[$];
  logic [7:0] exp_byte_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge clock) if (fim === 1'b1) fim_cnt++;

  always @(negedge clock) begin
    if (mon_en && mem_re === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: read of (%0d,%0d) with nothing expected",
                 mem_linha, mem_coluna);
      end else begin
        check("rd_addr", int'(mem_linha) * 1024 + int'(mem_coluna), exp_addr_q.pop_front());
      end
    end
  end

  // Serial receiver sampling mid-bit.
  initial begin
    logic [7:0] rx;
    forever begin
      @(negedge clock);
      if (mon_en && TX === 1'b0) begin
        repeat (CPB / 2) @(negedge clock);
        if (mon_en) check("rx_start", int'(TX), 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          rx[i] = TX;
        end
        repeat (CPB) @(negedge clock);
        if (mon_en) begin
          check("rx_stop", int'(TX), 1);
          if (exp_byte_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: byte 0x%0h with nothing expected", rx);
          end else begin
            check("rx_byte", int'(rx), int'(exp_byte_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic load_frame(input logic [47:0] bytes, input bit push);
    for (int i = 0; i < L * C; i++) begin
      mem[i] = bytes[8*i +: 8];
      if (push) begin
        exp_addr_q.push_back((i / C) * 1024 + (i % C));
        exp_byte_q.push_back(bytes[8*i +: 8]);
      end
    end
  endtask

  task automatic wait_fim();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 2 * FRAME && !seen; k++) begin
      @(negedge clock);
      if (fim === 1'b1) seen = 1'b1;
    end
    check("fim_seen", int'(seen), 1);
  endtask

  typedef struct {
    logic [47:0] bytes;
    logic        pronto;
    logic        retrig;
    logic        drop;
    int          exp_busy;
  } vec_t;

  task automatic run_frame(input vec_t v);
    int n, f0;
    bit any;
    load_frame(v.bytes, v.pronto);
    frame_pronto = v.pronto;
    f0 = fim_cnt;
    @(negedge clock) iniciar = 1'b1;
    @(negedge clock) check("ocupado_early", int'(ocupado), 0);
    @(negedge clock) check("ocupado_rise", int'(ocupado), int'(v.exp_busy != 0));
    if (v.exp_busy != 0) begin
      n = 0;
      while (ocupado === 1'b1 && n < 2 * FRAME) begin
        n++;
        if (v.retrig && n == 100) iniciar = 1'b0;
        if (v.retrig && n == 104) iniciar = 1'b1;
        if (v.drop && n == 50) frame_pronto = 1'b0;
        @(negedge clock);
      end
      check("busy_cycles", n, v.exp_busy);
      check("fim_pulse", int'(fim), 1);
      @(negedge clock);
      check("fim_single", int'(fim), 0);
      check("idle_state", int'(db_estado), 0);
      check("fim_count", fim_cnt - f0, 1);
      check("rd_queue_left", exp_addr_q.size(), 0);
      check("rx_queue_left", exp_byte_q.size(), 0);
    end else begin
      any = 1'b0;
      repeat (30) begin
        @(negedge clock);
        if (ocupado !== 1'b0 || mem_re !== 1'b0 || TX !== 1'b1) any = 1'b1;
      end
      check("ignored_start", int'(any), 0);
      check("ignored_state", int'(db_estado), 0);
    end
    iniciar = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors + 1);
    $fatal(1);
  end

  vec_t vecs[4];
  int pat[10];

  initial begin
    vecs[0] = '{48'h05_04_03_02_01_00, 1'b1, 1'b0, 1'b0, FRAME};
    vecs[1] = '{48'h11_22_33_44_55_66, 1'b0, 1'b0, 1'b0, 0};
    vecs[2] = '{48'h3C_81_00_FF_5A_A5, 1'b1, 1'b1, 1'b0, FRAME};
    vecs[3] = '{48'h24_C3_7F_80_01_FE, 1'b1, 1'b0, 1'b1, FRAME};
    pat = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    reset = 1'b0; iniciar = 1'b0; frame_pronto = 1'b0;
    w_iniciar = 1'b0; w_pronto = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_tx", int'(TX), 1);
    check("rst_ocupado", int'(ocupado), 0);
    check("rst_estado", int'(db_estado), 0);
    check("rst_mem_re", int'(mem_re), 0);
    check("rst_fim", int'(fim), 0);
    check("rst_addr", int'(mem_linha) * 1024 + int'(mem_coluna), 0);
    reset = 1'b1;
    begin
      bit any;
      any = 1'b0;
      repeat (20) begin
        @(negedge clock);
        if (ocupado !== 1'b0 || mem_re !== 1'b0 || TX !== 1'b1) any = 1'b1;
      end
      check("no_activity", int'(any), 0);
    end

    mon_en = 1'b1;
    for (int v = 0; v < 4; v++) run_frame(vecs[v]);

    // Exact 0xA5 bit timing and reported phases.
    load_frame(48'h05_04_03_02_01_A5, 1'b1);
    frame_pronto = 1'b1;
    @(negedge clock) iniciar = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clock);
        if (mem_re === 1'b1) seen = 1'b1;
      end
      check("a5_mem_re", int'(seen), 1);
    end
    check("a5_le_mem", int'(db_estado), 1);
    @(negedge clock) check("a5_espera", int'(db_estado), 2);
    check("a5_mem_re_width", int'(mem_re), 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      check("a5_bit", int'(TX), pat[i / CPB]);
      if (i == 0)  check("a5_ph_start", int'(db_estado), 3);
      if (i == 4)  check("a5_ph_dados", int'(db_estado), 4);
      if (i == 36) check("a5_ph_stop", int'(db_estado), 5);
    end
    @(negedge clock);
    check("a5_proximo", int'(db_estado), 6);
    check("a5_idle_tx", int'(TX), 1);
    wait_fim();
    iniciar = 1'b0;
    repeat (3) @(negedge clock);

    // Reset during data bit 3 of byte (0,1), then a clean restart.
    mon_en = 1'b0;
    load_frame(48'h05_04_03_02_00_00, 1'b0);
    frame_pronto = 1'b1;
    @(negedge clock) iniciar = 1'b1;
    repeat (2) @(negedge clock);
    check("rm_busy", int'(ocupado), 1);
    repeat (62) @(negedge clock);
    check("rm_phase", int'(db_estado), 4);
    check("rm_addr", int'(mem_linha) * 1024 + int'(mem_coluna), 1);
    check("rm_tx_low", int'(TX), 0);
    reset = 1'b0;
    #1;
    check("rm_tx_async", int'(TX), 1);
    check("rm_ocupado", int'(ocupado), 0);
    check("rm_estado", int'(db_estado), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    iniciar = 1'b0;
    repeat (2) @(negedge clock);
    mon_en = 1'b1;
    run_frame(vecs[0]);

    // Column wrap and final address on the wide instance.
    mon_en = 1'b0;
    w_pronto = 1'b1;
    @(negedge clock) w_iniciar = 1'b1;
    begin
      int el, ec, reads, bad, wraps, last_a, pl, pc;
      bit done;
      el = 0; ec = 0; reads = 0; bad = 0; wraps = 0; last_a = -1;
      pl = -1; pc = -1; done = 1'b0;
      for (int k = 0; k < WL * WC * 13 + 50 && !done; k++) begin
        @(negedge clock);
        if (w_mem_re === 1'b1) begin
          if (int'(w_linha) != el || int'(w_coluna) != ec) bad++;
          if (pc == WC - 1 && int'(w_coluna) == 0 && int'(w_linha) == pl + 1) wraps++;
          pl = int'(w_linha);
          pc = int'(w_coluna);
          last_a = pl * 1024 + pc;
          reads++;
          if (ec == WC - 1) begin ec = 0; el++; end
          else ec++;
        end
        if (w_fim === 1'b1) done = 1'b1;
      end
      check("wrap_fim", int'(done), 1);
      check("wrap_reads", reads, WL * WC);
      check("wrap_seq_errs", bad, 0);
      check("wrap_count", wraps, WL - 1);
      check("wrap_last", last_a, (WL - 1) * 1024 + (WC - 1));
    end
    w_iniciar = 1'b0;
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
